// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-requester SDRAM bridge arbiter.
package sdram_arb_pkg;

  localparam int unsigned DefAddrW      = 32;
  localparam int unsigned DefDataW      = 64;
  localparam int unsigned DefBurstW     = 8;
  localparam int unsigned DefMaxPending = 128;

  typedef enum logic [1:0] {
    StIdle,
    StRdGrant,
    StWrBurst
  } arb_state_e;

  typedef enum logic {
    ReqRead,
    ReqWrite
  } req_id_e;

endpackage

// File: rtl/sdram_read_tracker.sv
// Counts read beats accepted by the bridge but not yet returned; flags
// returns with nothing outstanding and any attempt to exceed the bound.
module sdram_read_tracker
  import sdram_arb_pkg::*;
#(
  parameter int unsigned BURST_W     = DefBurstW,
  parameter int unsigned MAX_PENDING = DefMaxPending,
  parameter int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               add_valid_i,
  input  logic [BURST_W-1:0] add_beats_i,
  input  logic               beat_valid_i,
  output logic [PEND_W-1:0]  pending_o,
  output logic               err_o
);

  logic [PEND_W-1:0] pending_q, pending_d;
  logic [31:0]       sum;
  logic              underflow;
  logic              overflow;

  always_comb begin
    underflow = beat_valid_i && (pending_q == '0);
    // A stray beat is not subtracted, so the counter can never wrap below zero.
    sum = 32'(pending_q)
        + (add_valid_i ? 32'(add_beats_i) : 32'd0)
        - ((beat_valid_i && !underflow) ? 32'd1 : 32'd0);
    overflow  = sum > MAX_PENDING;
    pending_d = overflow ? PEND_W'(MAX_PENDING) : PEND_W'(sum);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign err_o     = underflow || overflow;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM bridge port between a read-only
// pixel fetcher and a write-only result writer; write bursts hold the grant.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned BURST_W     = DefBurstW,
  parameter int unsigned MAX_PENDING = DefMaxPending,
  parameter int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   rd_address,
  input  logic [BURST_W-1:0]  rd_burstcount,
  input  logic                rd_read,
  output logic                rd_waitrequest,
  output logic [DATA_W-1:0]   rd_readdata,
  output logic                rd_readdatavalid,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic [BURST_W-1:0]  wr_burstcount,
  input  logic                wr_write,
  input  logic [DATA_W-1:0]   wr_writedata,
  input  logic [DATA_W/8-1:0] wr_byteenable,
  output logic                wr_waitrequest,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [BURST_W-1:0]  avm_burstcount,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [PEND_W-1:0]   pending_beats,
  output logic                err_sticky
);

  arb_state_e         state_q, state_d;
  req_id_e            last_q, last_d;
  logic [BURST_W-1:0] wr_rem_q, wr_rem_d;
  logic               wr_first_q, wr_first_d;
  logic               err_q, err_d;

  logic [BURST_W-1:0] rd_burst_eff;
  logic [BURST_W-1:0] wr_burst_eff;
  logic [BURST_W-1:0] wr_rem_next;
  logic               rd_eligible;
  logic               rd_accept;
  logic               cmd_err;
  logic               trk_err;

  // A zero burstcount is served as a single beat.
  assign rd_burst_eff = (rd_burstcount == '0) ? BURST_W'(1) : rd_burstcount;
  assign wr_burst_eff = (wr_burstcount == '0) ? BURST_W'(1) : wr_burstcount;
  assign rd_eligible  = rd_read &&
                        ((32'(pending_beats) + 32'(rd_burst_eff)) <= MAX_PENDING);

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    wr_rem_d       = wr_rem_q;
    wr_first_d     = wr_first_q;
    wr_rem_next    = '0;
    rd_accept      = 1'b0;
    cmd_err        = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = rd_address;
    avm_burstcount = rd_burstcount;
    rd_waitrequest = 1'b1;
    wr_waitrequest = 1'b1;

    unique case (state_q)
      StIdle: begin
        // On a tie the requester not served last wins.
        if (rd_eligible && (!wr_write || (last_q == ReqWrite))) begin
          state_d = StRdGrant;
        end else if (wr_write) begin
          state_d    = StWrBurst;
          wr_first_d = 1'b1;
        end
      end
      StRdGrant: begin
        avm_read       = 1'b1;
        rd_waitrequest = avm_waitrequest;
        if (!avm_waitrequest) begin
          rd_accept = 1'b1;
          cmd_err   = (rd_burstcount == '0);
          last_d    = ReqRead;
          state_d   = StIdle;
        end
      end
      StWrBurst: begin
        avm_write      = wr_write;
        avm_address    = wr_address;
        avm_burstcount = wr_burstcount;
        wr_waitrequest = avm_waitrequest;
        if (wr_write && !avm_waitrequest) begin
          if (wr_first_q) begin
            cmd_err     = (wr_burstcount == '0);
            wr_rem_next = wr_burst_eff - 1'b1;
          end else begin
            wr_rem_next = wr_rem_q - 1'b1;
          end
          wr_first_d = 1'b0;
          wr_rem_d   = wr_rem_next;
          if (wr_rem_next == '0) begin
            last_d  = ReqWrite;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    err_d = err_q | cmd_err | trk_err;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= StIdle;
      last_q     <= ReqWrite;
      wr_rem_q   <= '0;
      wr_first_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wr_rem_q   <= wr_rem_d;
      wr_first_q <= wr_first_d;
      err_q      <= err_d;
    end
  end

  sdram_read_tracker #(
    .BURST_W     (BURST_W),
    .MAX_PENDING (MAX_PENDING),
    .PEND_W      (PEND_W)
  ) u_read_tracker (
    .clk_i        (clk_clk),
    .rst_ni       (reset_reset_n),
    .add_valid_i  (rd_accept),
    .add_beats_i  (rd_burst_eff),
    .beat_valid_i (avm_readdatavalid),
    .pending_o    (pending_beats),
    .err_o        (trk_err)
  );

  assign avm_writedata    = wr_writedata;
  assign avm_byteenable   = wr_byteenable;
  assign rd_readdata      = avm_readdata;
  assign rd_readdatavalid = avm_readdatavalid;
  assign err_sticky       = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a bridge slave model returns read data
// while a negedge monitor checks every accepted command and beat against queues.
module tb_sdram_port_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] rd_address;
  logic [7:0]  rd_burstcount;
  logic        rd_read;
  logic        rd_waitrequest;
  logic [63:0] rd_readdata;
  logic        rd_readdatavalid;
  logic [31:0] wr_address;
  logic [7:0]  wr_burstcount;
  logic        wr_write;
  logic [63:0] wr_writedata;
  logic [7:0]  wr_byteenable;
  logic        wr_waitrequest;
  logic [31:0] avm_address;
  logic [7:0]  avm_burstcount;
  logic        avm_read;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [7:0]  pending_beats;
  logic        err_sticky;

  sdram_port_arbiter dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .rd_address        (rd_address),
    .rd_burstcount     (rd_burstcount),
    .rd_read           (rd_read),
    .rd_waitrequest    (rd_waitrequest),
    .rd_readdata       (rd_readdata),
    .rd_readdatavalid  (rd_readdatavalid),
    .wr_address        (wr_address),
    .wr_burstcount     (wr_burstcount),
    .wr_write          (wr_write),
    .wr_writedata      (wr_writedata),
    .wr_byteenable     (wr_byteenable),
    .wr_waitrequest    (wr_waitrequest),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .pending_beats     (pending_beats),
    .err_sticky        (err_sticky)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  burst;
  } cmd_t;

  int          tests = 0;
  int          fails = 0;
  cmd_t        exp_rd_cmd[$];
  cmd_t        exp_wr_cmd[$];
  logic [71:0] exp_wdata[$];
  logic [63:0] exp_rdata[$];
  logic [63:0] slave_q[$];
  string       cmd_log = "";
  int          rd_beats = 0;
  int          mon_wr_rem = 0;
  bit          ret_en = 1'b0;
  bit          stall_toggle = 1'b0;

  function automatic logic [63:0] rdat(input logic [31:0] a, input int i);
    return {a, 32'(i)} ^ 64'h5A5A_0000_0000_C3C3;
  endfunction

  function automatic logic [63:0] wdat(input logic [31:0] base, input int i);
    return {base, 32'(i)};
  endfunction

  function automatic int eff(input logic [7:0] b);
    return (b == 8'd0) ? 1 : int'(b);
  endfunction

  task automatic fail(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    fails++;
    $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic fails_str(input string tag, input string obs, input string exp);
    fails++;
    $error("FAIL %s: observed %s, expected %s", tag, obs, exp);
  endtask

  // Bridge-side monitor: checks commands, write beats and returned read data.
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      mon_wr_rem = 0;
    end else begin
      if (avm_read && !avm_waitrequest) begin
        cmd_log = {cmd_log, "R"};
        tests++;
        if (exp_rd_cmd.size() == 0) fail("rd_cmd_expected", 0, 1);
        if (exp_rd_cmd.size() != 0) begin
          cmd_t c;
          c = exp_rd_cmd.pop_front();
          tests++;
          if ({avm_address, avm_burstcount} !== c) fail("rd_cmd", {avm_address, avm_burstcount}, c);
        end
        for (int i = 0; i < eff(avm_burstcount); i++) slave_q.push_back(rdat(avm_address, i));
      end
      if (avm_write && !avm_waitrequest) begin
        cmd_log = {cmd_log, "W"};
        if (mon_wr_rem == 0) begin
          tests++;
          if (exp_wr_cmd.size() == 0) fail("wr_cmd_expected", 0, 1);
          if (exp_wr_cmd.size() != 0) begin
            cmd_t c;
            c = exp_wr_cmd.pop_front();
            tests++;
            if ({avm_address, avm_burstcount} !== c) begin
              fail("wr_cmd", {avm_address, avm_burstcount}, c);
            end
          end
          mon_wr_rem = eff(avm_burstcount);
        end
        mon_wr_rem--;
        tests++;
        if (exp_wdata.size() == 0) fail("wr_beat_expected", 0, 1);
        if (exp_wdata.size() != 0) begin
          logic [71:0] w;
          w = exp_wdata.pop_front();
          tests++;
          if ({avm_writedata, avm_byteenable} !== w) begin
            fail("wr_beat", {avm_writedata, avm_byteenable}, w);
          end
        end
      end
      if (rd_readdatavalid) begin
        rd_beats++;
        tests++;
        if (exp_rdata.size() == 0) fail("rd_beat_expected", 0, 1);
        if (exp_rdata.size() != 0) begin
          logic [63:0] d;
          d = exp_rdata.pop_front();
          tests++;
          if (rd_readdata !== d) fail("rd_data", rd_readdata, d);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic rd_issue(input logic [31:0] a, input logic [7:0] b);
    bit acc = 1'b0;
    exp_rd_cmd.push_back({a, b});
    for (int i = 0; i < eff(b); i++) exp_rdata.push_back(rdat(a, i));
    rd_address    = a;
    rd_burstcount = b;
    rd_read       = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_clk);
      if (!rd_waitrequest) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) sync();
    rd_read = 1'b0;
    tests++;
    if (acc !== 1'b1) fail("rd_accept_in_time", acc, 1);
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [7:0] b, input logic [31:0] base);
    bit acc;
    exp_wr_cmd.push_back({a, b});
    for (int i = 0; i < eff(b); i++) exp_wdata.push_back({wdat(base, i), 8'hF0 ^ 8'(i)});
    wr_address    = a;
    wr_burstcount = b;
    for (int i = 0; i < eff(b); i++) begin
      wr_writedata  = wdat(base, i);
      wr_byteenable = 8'hF0 ^ 8'(i);
      wr_write      = 1'b1;
      acc           = 1'b0;
      for (int n = 0; n < 400; n++) begin
        @(negedge clk_clk);
        if (!wr_waitrequest) begin
          acc = 1'b1;
          break;
        end
      end
      tests++;
      if (acc !== 1'b1) fail("wr_accept_in_time", acc, 1);
      if (!acc) break;
      sync();
    end
    wr_write = 1'b0;
  endtask

  task automatic drain();
    ret_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk_clk);
      if (pending_beats == 8'd0 && slave_q.size() == 0) break;
    end
    sync();
    ret_en = 1'b0;
    tests++;
    if (pending_beats !== 8'd0) fail("drain_pending_zero", pending_beats, 0);
    tests++;
    if (exp_rdata.size() != 0) fail("drain_rdata_all_seen", exp_rdata.size(), 0);
  endtask

  initial begin
    reset_reset_n     = 1'b0;
    rd_address        = '0;
    rd_burstcount     = '0;
    rd_read           = 1'b0;
    wr_address        = '0;
    wr_burstcount     = '0;
    wr_write          = 1'b0;
    wr_writedata      = '0;
    wr_byteenable     = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;

    // Bridge slave model: waitrequest pattern and read-data return.
    fork
      forever begin
        @(posedge clk_clk);
        #2;
        avm_waitrequest = stall_toggle ? ~avm_waitrequest : 1'b0;
        if (ret_en && slave_q.size() != 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = slave_q.pop_front();
        end else begin
          avm_readdatavalid = 1'b0;
        end
      end
    join_none

    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    tests++;
    if (avm_read !== 1'b0) fail("reset_avm_read", avm_read, 0);
    tests++;
    if (avm_write !== 1'b0) fail("reset_avm_write", avm_write, 0);
    tests++;
    if (rd_waitrequest !== 1'b1) fail("reset_rd_waitrequest", rd_waitrequest, 1);
    tests++;
    if (wr_waitrequest !== 1'b1) fail("reset_wr_waitrequest", wr_waitrequest, 1);
    tests++;
    if (rd_readdatavalid !== 1'b0) fail("reset_rd_readdatavalid", rd_readdatavalid, 0);
    tests++;
    if (pending_beats !== 8'd0) fail("reset_pending", pending_beats, 0);
    tests++;
    if (err_sticky !== 1'b0) fail("reset_err", err_sticky, 0);
    sync();
    reset_reset_n = 1'b1;
    sync();

    // Both requesters busy: fresh reset lets the reader win the first tie.
    ret_en  = 1'b1;
    cmd_log = "";
    fork
      begin
        rd_issue(32'h0000_0100, 8'd8);
        rd_issue(32'h0000_0200, 8'd8);
      end
      begin
        wr_burst(32'h0000_0300, 8'd4, 32'hAAAA_0001);
        wr_burst(32'h0000_0400, 8'd4, 32'hAAAA_0002);
      end
    join
    tests++;
    if (cmd_log != "RWWWWRWWWW") fails_str("alternating_grants", cmd_log, "RWWWWRWWWW");
    drain();

    // Reader alone: four bursts of 16 outstanding at once.
    ret_en   = 1'b0;
    rd_beats = 0;
    for (int i = 0; i < 4; i++) rd_issue(32'h0000_1000 + 32'(i * 256), 8'd16);
    @(negedge clk_clk);
    tests++;
    if (pending_beats !== 8'd64) fail("reader_only_peak_pending", pending_beats, 64);
    sync();
    drain();
    tests++;
    if (rd_beats != 64) fail("reader_only_beats_returned", rd_beats, 64);

    // Writer burst under toggling waitrequest locks out a waiting reader.
    stall_toggle = 1'b1;
    cmd_log      = "";
    fork
      wr_burst(32'h0000_5000, 8'd8, 32'hBBBB_0001);
      rd_issue(32'h0000_6000, 8'd4);
    join
    stall_toggle = 1'b0;
    tests++;
    if (cmd_log != "WWWWWWWWR") fails_str("write_lock_order", cmd_log, "WWWWWWWWR");
    sync();
    drain();

    // Pending bound: second read blocked at 128 until four beats come back.
    cmd_log = "";
    rd_issue(32'h0001_0000, 8'd128);
    @(negedge clk_clk);
    tests++;
    if (pending_beats !== 8'd128) fail("bound_pending_full", pending_beats, 128);
    sync();
    fork
      rd_issue(32'h0002_0000, 8'd4);
      begin
        wr_burst(32'h0003_0000, 8'd4, 32'hCCCC_0001);
        tests++;
        if (cmd_log != "RWWWW") fails_str("bound_read_blocked", cmd_log, "RWWWW");
        tests++;
        if (pending_beats !== 8'd128) fail("bound_pending_held", pending_beats, 128);
        ret_en = 1'b1;
        repeat (4) @(posedge clk_clk);
        #1;
        ret_en = 1'b0;
      end
    join
    @(negedge clk_clk);
    tests++;
    if (cmd_log != "RWWWWR") fails_str("bound_read_after_return", cmd_log, "RWWWWR");
    tests++;
    if (pending_beats !== 8'd128) fail("bound_pending_refilled", pending_beats, 128);
    sync();
    drain();

    // Read accept coinciding with a returning beat.
    rd_issue(32'h0000_7000, 8'd3);
    @(negedge clk_clk);
    tests++;
    if (pending_beats !== 8'd3) fail("overlap_pending_before", pending_beats, 3);
    sync();
    fork
      rd_issue(32'h0000_7100, 8'd4);
      begin
        sync();
        ret_en = 1'b1;
        sync();
        ret_en = 1'b0;
      end
    join
    @(negedge clk_clk);
    tests++;
    if (pending_beats !== 8'd6) fail("overlap_pending_after", pending_beats, 6);
    sync();
    drain();

    // Zero burstcount is served as one beat and latches the error.
    tests++;
    if (err_sticky !== 1'b0) fail("zero_burst_err_before", err_sticky, 0);
    rd_issue(32'h0000_8000, 8'd0);
    @(negedge clk_clk);
    tests++;
    if (err_sticky !== 1'b1) fail("zero_burst_err_set", err_sticky, 1);
    tests++;
    if (pending_beats !== 8'd1) fail("zero_burst_pending", pending_beats, 1);
    sync();
    drain();
    tests++;
    if (err_sticky !== 1'b1) fail("zero_burst_err_sticky", err_sticky, 1);

    // Asynchronous reset in the middle of a write burst.
    exp_wr_cmd.push_back({32'h0000_9000, 8'd8});
    for (int i = 0; i < 8; i++) exp_wdata.push_back({64'hDEAD_BEEF_0000_0009, 8'hFF});
    wr_address    = 32'h0000_9000;
    wr_burstcount = 8'd8;
    wr_writedata  = 64'hDEAD_BEEF_0000_0009;
    wr_byteenable = 8'hFF;
    wr_write      = 1'b1;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    tests++;
    if (avm_write !== 1'b1) fail("midburst_write_active", avm_write, 1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    tests++;
    if (avm_write !== 1'b0) fail("async_reset_avm_write", avm_write, 0);
    tests++;
    if (wr_waitrequest !== 1'b1) fail("async_reset_wr_waitrequest", wr_waitrequest, 1);
    tests++;
    if (rd_waitrequest !== 1'b1) fail("async_reset_rd_waitrequest", rd_waitrequest, 1);
    tests++;
    if (err_sticky !== 1'b0) fail("async_reset_err", err_sticky, 0);
    tests++;
    if (pending_beats !== 8'd0) fail("async_reset_pending", pending_beats, 0);
    wr_write = 1'b0;
    exp_wr_cmd.delete();
    exp_wdata.delete();
    sync();
    reset_reset_n = 1'b1;
    repeat (2) sync();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
